pio_fault_filter: RTL and testbench

Parametrised multi-channel fault-input PIO, an Avalon-MM slave for hull/driver fault lines.
- Synchronises and debounces WIDTH asynchronous fault inputs.
- Latches qualified edges in a write-1-to-clear capture register.
- Raises a maskable interrupt to the soft CPU.
- Sits between the fault pins and the system interconnect and replaces the per-pin single-bit PIOs.

---
 rtl/pio_fault_filter.sv | 106 ++++++++++
 tb/tb_pio_fault_filter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_fault_filter.sv
// Multi-channel fault-input PIO: synchronise, debounce, capture edges, raise a maskable irq.
// Define PIO_FAULT_IRQ_REG_EN to register irq (one extra cycle of latency); default is combinational.
module pio_fault_filter #(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 16,
   parameter int EDGE_MODE   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             write,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   localparam int CW = $clog2(FILT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

   logic [WIDTH-1:0] sync_pipe [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] filt;
   logic [WIDTH-1:0] filt_next;
   logic [WIDTH-1:0] flip;
   logic [WIDTH-1:0] set_bits;
   logic [WIDTH-1:0] clr_bits;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [CW-1:0]    cnt      [WIDTH];
   logic [CW-1:0]    cnt_next [WIDTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= '0;
      end else begin
         sync_pipe[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
      end
   end

   assign sync = sync_pipe[SYNC_STAGES-1];

   // A channel only flips after FILT_CYCLES consecutive mismatches; any match restarts the count.
   always_comb begin
      flip = '0;
      for (int ch = 0; ch < WIDTH; ch++) begin
         cnt_next[ch] = '0;
         if (sync[ch] != filt[ch]) begin
            if (cnt[ch] == CNT_LAST) flip[ch] = 1'b1;
            else                     cnt_next[ch] = cnt[ch] + CW'(1);
         end
      end
   end

   assign filt_next = filt ^ flip;

   if (EDGE_MODE == 0) begin : g_rise
      assign set_bits = flip & filt_next;
   end else if (EDGE_MODE == 1) begin : g_fall
      assign set_bits = flip & ~filt_next;
   end else begin : g_any
      assign set_bits = flip;
   end

   assign clr_bits = (write && address == 2'd3) ? writedata : '0;

   // Set is OR-ed after the clear so a capture on the clearing edge is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt        <= '0;
         irqmask     <= '0;
         edgecapture <= '0;
         for (int ch = 0; ch < WIDTH; ch++) cnt[ch] <= '0;
      end else begin
         filt        <= filt_next;
         edgecapture <= (edgecapture & ~clr_bits) | set_bits;
         if (write && address == 2'd2) irqmask <= writedata;
         for (int ch = 0; ch < WIDTH; ch++) cnt[ch] <= cnt_next[ch];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         case (address)
            2'd0:    readdata <= filt;
            2'd1:    readdata <= sync;
            2'd2:    readdata <= irqmask;
            default: readdata <= edgecapture;
         endcase
      end
   end

`ifdef PIO_FAULT_IRQ_REG_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq <= 1'b0;
      else       irq <= |(edgecapture & irqmask);
   end
`else
   assign irq = |(edgecapture & irqmask);
`endif

endmodule

// File: tb/tb_pio_fault_filter.sv
// Bench for pio_fault_filter: three edge modes side by side, directed steps plus random traffic,
// checked against a sliding-window history model of the filter.
module tb_pio_fault_filter;

   localparam int SYNC = 2;
   localparam int FILT = 16;
`ifdef PIO_FAULT_IRQ_REG_EN
   localparam bit IRQ_REG = 1'b1;
`else
   localparam bit IRQ_REG = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] address;
   logic       write;
   logic [3:0] writedata;
   logic [3:0] in_port;
   logic [3:0] rd0, rd1, rd2;
   logic       irq0, irq1, irq2;

   int checks   = 0;
   int failures = 0;

   logic [3:0] in_h   [$];
   logic [3:0] sync_h [$];
   logic [3:0] m_filt;
   logic [3:0] m_ecap [3];
   logic [3:0] m_mask [3];
   logic [3:0] m_rd   [3];
   logic       m_irq  [3];

   pio_fault_filter #(.WIDTH(4), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .EDGE_MODE(0)) dut0 (
      .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
      .in_port(in_port), .readdata(rd0), .irq(irq0));
   pio_fault_filter #(.WIDTH(4), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .EDGE_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
      .in_port(in_port), .readdata(rd1), .irq(irq1));
   pio_fault_filter #(.WIDTH(4), .SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .EDGE_MODE(2)) dut2 (
      .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
      .in_port(in_port), .readdata(rd2), .irq(irq2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      in_h.delete();
      sync_h.delete();
      sync_h.push_back(4'h0);
      m_filt = 4'h0;
      for (int m = 0; m < 3; m++) begin
         m_ecap[m] = 4'h0;
         m_mask[m] = 4'h0;
         m_rd[m]   = 4'h0;
         m_irq[m]  = 1'b0;
      end
   endtask

   // filt flips when the last FILT sync samples all disagree with it (history before reset reads as 0)
   task automatic model_edge();
      int n;
      logic [3:0] filt_o, sync_o, flip, filt_n, set_v, clr;
      logic s;
      n      = sync_h.size();
      filt_o = m_filt;
      sync_o = sync_h[n-1];
      flip   = 4'hF;
      for (int ch = 0; ch < 4; ch++)
         for (int j = 1; j <= FILT; j++) begin
            s = (n - j >= 0) ? sync_h[n-j][ch] : 1'b0;
            if (s == filt_o[ch]) flip[ch] = 1'b0;
         end
      filt_n = filt_o ^ flip;
      in_h.push_back(in_port);
      sync_h.push_back(in_h.size() >= SYNC ? in_h[in_h.size()-SYNC] : 4'h0);
      clr = (write && address == 2'd3) ? writedata : 4'h0;
      for (int m = 0; m < 3; m++) begin
         set_v = (m == 0) ? (flip & filt_n) : (m == 1) ? (flip & ~filt_n) : flip;
         case (address)
            2'd0: m_rd[m] = filt_o;
            2'd1: m_rd[m] = sync_o;
            2'd2: m_rd[m] = m_mask[m];
            default: m_rd[m] = m_ecap[m];
         endcase
         if (IRQ_REG) m_irq[m] = |(m_ecap[m] & m_mask[m]);
         m_ecap[m] = (m_ecap[m] & ~clr) | set_v;
         if (write && address == 2'd2) m_mask[m] = writedata;
         if (!IRQ_REG) m_irq[m] = |(m_ecap[m] & m_mask[m]);
      end
      m_filt = filt_n;
   endtask

   task automatic check_output();
      check_eq("rd0",  32'(rd0),  32'(m_rd[0]));
      check_eq("rd1",  32'(rd1),  32'(m_rd[1]));
      check_eq("rd2",  32'(rd2),  32'(m_rd[2]));
      check_eq("irq0", 32'(irq0), 32'(m_irq[0]));
      check_eq("irq1", 32'(irq1), 32'(m_irq[1]));
      check_eq("irq2", 32'(irq2), 32'(m_irq[2]));
   endtask

   task automatic apply_stimulus();
      @(posedge clk);
      model_edge();
      #1;
      check_output();
   endtask

   task automatic steps(input int count);
      for (int i = 0; i < count; i++) apply_stimulus();
   endtask

   // Called just after an edge; outputs must clear as soon as reset rises.
   task automatic do_reset(input logic [3:0] pin);
      reset   = 1'b1;
      in_port = pin;
      write   = 1'b0;
      address = 2'd0;
      #1;
      check_eq("reset_rd0",  32'(rd0),  32'h0);
      check_eq("reset_rd1",  32'(rd1),  32'h0);
      check_eq("reset_rd2",  32'(rd2),  32'h0);
      check_eq("reset_irq0", 32'(irq0), 32'h0);
      check_eq("reset_irq1", 32'(irq1), 32'h0);
      check_eq("reset_irq2", 32'(irq2), 32'h0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic write_reg(input logic [1:0] a, input logic [3:0] d);
      address   = a;
      write     = 1'b1;
      writedata = d;
      apply_stimulus();
      write     = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      address   = 2'd0;
      write     = 1'b0;
      writedata = 4'h0;
      in_port   = 4'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;

      // all faults high through reset, then qualify
      do_reset(4'hF);
      write_reg(2'd2, 4'h1);
      address = 2'd3;
      steps(19);
      check_eq("allhigh_ecap", 32'(rd0), 32'hF);
      check_eq("allhigh_irq",  32'(irq0), 32'h1);

      // short pulse on ch2 must be rejected
      do_reset(4'h0);
      write_reg(2'd2, 4'hF);
      address = 2'd3;
      in_port = 4'h4;
      steps(10);
      in_port = 4'h0;
      steps(30);
      check_eq("glitch_ecap0", 32'(rd0),  32'h0);
      check_eq("glitch_ecap2", 32'(rd2),  32'h0);
      check_eq("glitch_irq",   32'(irq0), 32'h0);

      // clean rising step on ch1: filt flips at edge 18, readdata shows it at 19
      do_reset(4'h2);
      write_reg(2'd2, 4'h2);
      address = 2'd0;
      for (int e = 2; e <= 20; e++) begin
         apply_stimulus();
         if (e == 17) check_eq("lat_irq17", 32'(irq0), 32'h0);
         if (e == 18) begin
            check_eq("lat_rd18",  32'(rd0),  32'h0);
            check_eq("lat_irq18", 32'(irq0), 32'(!IRQ_REG));
         end
         if (e == 19) begin
            check_eq("lat_rd19",  32'(rd0),  32'h2);
            check_eq("lat_irq19", 32'(irq0), 32'h1);
         end
      end
      address = 2'd3;
      apply_stimulus();
      check_eq("lat_ecap", 32'(rd0), 32'h2);

      // write-1-to-clear, then a clear colliding with a fresh rise on ch1
      in_port = 4'h3;
      steps(20);
      write_reg(2'd3, 4'h1);
      apply_stimulus();
      check_eq("w1c_ecap", 32'(rd0), 32'h2);
      in_port = 4'h1;
      steps(20);
      in_port = 4'h3;
      steps(17);
      write_reg(2'd3, 4'h2);
      address = 2'd3;
      apply_stimulus();
      check_eq("collide_ecap", 32'(rd0), 32'h2);

      // edge-mode differences on ch0
      do_reset(4'h0);
      address = 2'd3;
      in_port = 4'h1;
      steps(20);
      check_eq("rise_mode0", 32'(rd0), 32'h1);
      check_eq("rise_mode1", 32'(rd1), 32'h0);
      check_eq("rise_mode2", 32'(rd2), 32'h1);
      in_port = 4'h0;
      steps(20);
      check_eq("fall_mode1", 32'(rd1), 32'h1);
      check_eq("fall_mode2", 32'(rd2), 32'h1);

      // mask gating, then reset in the middle of a count
      do_reset(4'h0);
      write_reg(2'd2, 4'h7);
      address = 2'd3;
      in_port = 4'h8;
      steps(20);
      check_eq("mask_ecap", 32'(rd0),  32'h8);
      check_eq("mask_irq0", 32'(irq0), 32'h0);
      write_reg(2'd2, 4'hF);
      apply_stimulus();
      check_eq("mask_irq1", 32'(irq0), 32'h1);
      in_port = 4'h0;
      steps(5);
      do_reset(4'h0);

      // random traffic with slowly toggling inputs and a reset in the middle
      for (int c = 0; c < 500; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(19) == 0) in_port[b] = ~in_port[b];
         address   = 2'($urandom_range(3));
         write     = ($urandom_range(7) == 0);
         writedata = 4'($urandom);
         if (c == 250) do_reset(in_port);
         else          apply_stimulus();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
